mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port simulation/FPGA memory between the Pipeline data/instruction port (port A) and a secondary requester (port B, e.g. debug loader or DMA).
- The Pipeline memory interface has no ready/stall signal, so port A always has absolute priority.
- Port B is accepted into a one-entry holding buffer and issued on the next cycle in which A is idle.
- Read latency of the memory is one cycle; the block routes responses back to the owning port and flags starvation of B.

Parameters:
ADDR_WIDTH, 32, width of byte address on all ports
WAIT_WIDTH, 8, width of the B wait counter (saturating)
STARVE_LIMIT, 64, wait cycles at or above which starved is asserted; must be < 2**WAIT_WIDTH

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
a_valid  input  1  Pipeline request this cycle (never stalled)
a_write  input  1  Pipeline write
a_wmask  input  4  Pipeline byte write mask
a_wdata  input  32  Pipeline write data
a_wgrubby  input  1  Pipeline write grubby bit
a_addr  input  ADDR_WIDTH  Pipeline address
a_rdata  output  32  read data to Pipeline (= mem_rdata)
a_rgrubby  output  1  grubby bit to Pipeline (= mem_rgrubby)
b_valid  input  1  B request
b_ready  output  1  B request accepted this cycle when b_valid & b_ready
b_write, b_wmask(4), b_wdata(32), b_wgrubby(1), b_addr(ADDR_WIDTH)  input  -  B request fields
b_rvalid  output  1  B read data valid this cycle
b_rdata  output  32  B read data (= mem_rdata, qualified by b_rvalid)
b_rgrubby  output  1  B grubby bit (= mem_rgrubby, qualified by b_rvalid)
mem_valid, mem_write, mem_wmask(4), mem_wdata(32), mem_wgrubby(1), mem_addr(ADDR_WIDTH)  output  -  to memory
mem_rdata  input  32  memory read data, one cycle after request
mem_rgrubby  input  1  memory read grubby bit
starved  output  1  B pending for >= STARVE_LIMIT cycles
wait_count  output  WAIT_WIDTH  cycles current B request has waited

Behaviour:
- States: IDLE (buffer empty), PEND (buffer holds one B request).
- issue_b = (state==PEND) & !a_valid.
- b_ready = (state==IDLE) | issue_b; combinational in a_valid.
- Accept when b_valid & b_ready: capture all b_* fields into the buffer; next state PEND.
- PEND -> IDLE when issue_b and no new accept. PEND -> PEND when issue_b and a new accept in the same cycle (back-to-back B at 1/cycle while A idle). PEND holds while a_valid=1.
- Memory mux (combinational):
  - a_valid=1: mem_* = a_*.
  - else issue_b: mem_* = buffer fields.
  - else: mem_valid=0, mem_write=0, mem_wmask=0; other fields don't-care, drive 0.
- A accepted in same cycle as PEND: A wins, buffer unchanged.
- Response:
  - q_b_read <= issue_b & !buf_write; b_rvalid = q_b_read.
  - a_rdata/a_rgrubby are wired to mem_* unconditionally; the Pipeline ignores cycles it did not request.
- B latency: accepted cycle N with A idle -> issued N+1 -> b_rvalid at N+2. Writes produce no b_rvalid.
- Wait counter:
  - Cleared on accept.
  - +1 each cycle in PEND without issue_b, saturating at 2**WAIT_WIDTH-1.
  - Cleared on issue (unless re-accept, which also clears).
  - starved = (state==PEND) & (wait_count >= STARVE_LIMIT).
- Reset (rst=1 at edge): state IDLE, buffer cleared, q_b_read=0, wait_count=0. A pending B request is dropped. A B read issued the cycle before reset gets no b_rvalid.
- Outputs after reset: b_rvalid=0, starved=0, wait_count=0, b_ready=1, mem_valid follows a_valid.
- Address passes unmodified; no alignment checking.

Test Plan:
- Reset, a_valid=0, B read addr 0x100 at cycle 0 -> b_ready=1; mem_valid=1/mem_addr=0x100 at cycle 1; b_rvalid=1 with b_rdata=mem[0x100] at cycle 2.
- a_valid=1 for 10 cycles, B write 0x200 data 0xDEADBEEF mask 0xF accepted at cycle 0 -> no B issue while A busy; wait_count=10; write issued the first cycle a_valid=0; memory holds 0xDEADBEEF; no b_rvalid.
- STARVE_LIMIT=4, a_valid held 1, B pending -> starved rises when wait_count=4, clears the cycle after B issues.
- a_valid=0, b_valid=1 every cycle with addresses 0x0,0x4,0x8 -> b_ready=1 each cycle; three consecutive mem reads; b_rvalid high for three consecutive cycles with matching data.
- A and pending B collide: a_valid=1 addr 0x40, buffer addr 0x80 -> mem_addr=0x40, b_ready=0; next cycle a_valid=0 -> mem_addr=0x80.
- rst asserted while PEND and while a B read is in flight -> next cycle state IDLE, b_rvalid=0, wait_count=0, buffered request never reaches memory.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: the Pipeline port (A) always wins. A secondary
// requester (B) is parked in a one-entry buffer and issued on a cycle when A is idle.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int WAIT_WIDTH   = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_valid,
    input  logic                  a_write,
    input  logic [3:0]            a_wmask,
    input  logic [31:0]           a_wdata,
    input  logic                  a_wgrubby,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic [31:0]           a_rdata,
    output logic                  a_rgrubby,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_write,
    input  logic [3:0]            b_wmask,
    input  logic [31:0]           b_wdata,
    input  logic                  b_wgrubby,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_rvalid,
    output logic [31:0]           b_rdata,
    output logic                  b_rgrubby,

    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic                  mem_wgrubby,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rgrubby,

    output logic                  starved,
    output logic [WAIT_WIDTH-1:0] wait_count
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [WAIT_WIDTH-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_WIDTH-1:0] STARVE_TH = WAIT_WIDTH'(STARVE_LIMIT);

    state_t                  state_q, state_d;
    logic                    buf_write_q, buf_write_d;
    logic [3:0]              buf_wmask_q, buf_wmask_d;
    logic [31:0]             buf_wdata_q, buf_wdata_d;
    logic                    buf_wgrubby_q, buf_wgrubby_d;
    logic [ADDR_WIDTH-1:0]   buf_addr_q, buf_addr_d;
    logic                    b_read_q, b_read_d;
    logic [WAIT_WIDTH-1:0]   wait_q, wait_d;

    logic                    issue_b;
    logic                    accept;

    function automatic logic [WAIT_WIDTH-1:0] sat_inc(input logic [WAIT_WIDTH-1:0] v);
        return (v == WAIT_MAX) ? v : v + 1'b1;
    endfunction

    assign issue_b = (state_q == PEND) && !a_valid;
    assign b_ready = (state_q == IDLE) || issue_b;
    assign accept  = b_valid && b_ready;

    always_comb begin
        state_d       = state_q;
        buf_write_d   = buf_write_q;
        buf_wmask_d   = buf_wmask_q;
        buf_wdata_d   = buf_wdata_q;
        buf_wgrubby_d = buf_wgrubby_q;
        buf_addr_d    = buf_addr_q;
        wait_d        = wait_q;
        b_read_d      = issue_b && !buf_write_q;

        // A new accept overrides the issue-driven return to IDLE so B can stream at 1/cycle.
        if (accept) begin
            state_d       = PEND;
            buf_write_d   = b_write;
            buf_wmask_d   = b_wmask;
            buf_wdata_d   = b_wdata;
            buf_wgrubby_d = b_wgrubby;
            buf_addr_d    = b_addr;
            wait_d        = '0;
        end else if (issue_b) begin
            state_d = IDLE;
            wait_d  = '0;
        end else if (state_q == PEND) begin
            wait_d = sat_inc(wait_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            buf_write_q   <= 1'b0;
            buf_wmask_q   <= '0;
            buf_wdata_q   <= '0;
            buf_wgrubby_q <= 1'b0;
            buf_addr_q    <= '0;
            b_read_q      <= 1'b0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            buf_write_q   <= buf_write_d;
            buf_wmask_q   <= buf_wmask_d;
            buf_wdata_q   <= buf_wdata_d;
            buf_wgrubby_q <= buf_wgrubby_d;
            buf_addr_q    <= buf_addr_d;
            b_read_q      <= b_read_d;
            wait_q        <= wait_d;
        end
    end

    always_comb begin
        mem_valid   = 1'b0;
        mem_write   = 1'b0;
        mem_wmask   = '0;
        mem_wdata   = '0;
        mem_wgrubby = 1'b0;
        mem_addr    = '0;
        if (a_valid) begin
            mem_valid   = 1'b1;
            mem_write   = a_write;
            mem_wmask   = a_wmask;
            mem_wdata   = a_wdata;
            mem_wgrubby = a_wgrubby;
            mem_addr    = a_addr;
        end else if (issue_b) begin
            mem_valid   = 1'b1;
            mem_write   = buf_write_q;
            mem_wmask   = buf_wmask_q;
            mem_wdata   = buf_wdata_q;
            mem_wgrubby = buf_wgrubby_q;
            mem_addr    = buf_addr_q;
        end
    end

    // The Pipeline ignores response cycles it did not request, so A data is unqualified.
    assign a_rdata    = mem_rdata;
    assign a_rgrubby  = mem_rgrubby;
    assign b_rvalid   = b_read_q;
    assign b_rdata    = mem_rdata;
    assign b_rgrubby  = mem_rgrubby;
    assign wait_count = wait_q;
    assign starved    = (state_q == PEND) && (wait_q >= STARVE_TH);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors feed expected memory issues and
// B read responses into queues that negedge monitors pop and compare.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_write, a_wgrubby;
    logic [3:0]  a_wmask;
    logic [31:0] a_wdata, a_addr, a_rdata;
    logic        a_rgrubby;
    logic        b_valid, b_ready, b_write, b_wgrubby;
    logic [3:0]  b_wmask;
    logic [31:0] b_wdata, b_addr;
    logic        b_rvalid;
    logic [31:0] b_rdata;
    logic        b_rgrubby;
    logic        mem_valid, mem_write, mem_wgrubby;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata, mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rgrubby;
    logic        starved;
    logic [3:0]  wait_count;

    mem_port_arbiter #(.ADDR_WIDTH(32), .WAIT_WIDTH(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_write(a_write), .a_wmask(a_wmask), .a_wdata(a_wdata),
        .a_wgrubby(a_wgrubby), .a_addr(a_addr), .a_rdata(a_rdata), .a_rgrubby(a_rgrubby),
        .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_wmask(b_wmask),
        .b_wdata(b_wdata), .b_wgrubby(b_wgrubby), .b_addr(b_addr),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_rgrubby(b_rgrubby),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_wgrubby(mem_wgrubby), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rgrubby(mem_rgrubby),
        .starved(starved), .wait_count(wait_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        g;
    } mem_t;

    typedef struct packed {
        logic [31:0] data;
        logic        g;
    } rsp_t;

    mem_t exp_mem[$];
    rsp_t exp_rsp[$];
    mem_t me;
    rsp_t re;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    // Memory: word i holds 32'hC0DE0000 + 4*i, grubby = address bit 2.
    logic [31:0] mem_arr [256];
    logic        gr_arr  [256];
    logic [7:0]  idx;
    assign idx = mem_addr[9:2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem_arr[i] <= 32'hC0DE0000 + 32'(i * 4);
                gr_arr[i]  <= 1'(i & 1);
            end
        end else if (mem_valid) begin
            if (mem_write) begin
                for (int k = 0; k < 4; k++)
                    if (mem_wmask[k]) mem_arr[idx][8*k +: 8] <= mem_wdata[8*k +: 8];
                gr_arr[idx] <= mem_wgrubby;
            end else begin
                mem_rdata   <= mem_arr[idx];
                mem_rgrubby <= gr_arr[idx];
            end
        end
    end

    always @(negedge clk) begin
        if (mem_valid) begin
            tot_cnt++;
            if (exp_mem.size() == 0) begin
                $display("FAIL mem_issue: got w=%0b addr=%h, required no memory request", mem_write, mem_addr);
            end else begin
                me = exp_mem.pop_front();
                if (mem_write === me.w && mem_addr === me.addr &&
                    (!me.w || (mem_wdata === me.wdata && mem_wmask === me.mask && mem_wgrubby === me.g)))
                    pass_cnt++;
                else
                    $display("FAIL mem_issue: got w=%0b addr=%h d=%h m=%h g=%0b, required w=%0b addr=%h d=%h m=%h g=%0b",
                             mem_write, mem_addr, mem_wdata, mem_wmask, mem_wgrubby,
                             me.w, me.addr, me.wdata, me.mask, me.g);
            end
        end
        if (b_rvalid) begin
            tot_cnt++;
            if (exp_rsp.size() == 0) begin
                $display("FAIL b_rsp: got b_rvalid with data %h, required no response", b_rdata);
            end else begin
                re = exp_rsp.pop_front();
                if (b_rdata === re.data && b_rgrubby === re.g)
                    pass_cnt++;
                else
                    $display("FAIL b_rsp: got data=%h g=%0b, required data=%h g=%0b",
                             b_rdata, b_rgrubby, re.data, re.g);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic w, input logic [31:0] addr,
                           input logic [31:0] d, input logic [3:0] m, input logic g);
        a_valid = v; a_write = w; a_addr = addr; a_wdata = d; a_wmask = m; a_wgrubby = g;
    endtask

    task automatic drive_b(input logic v, input logic w, input logic [31:0] addr,
                           input logic [31:0] d, input logic [3:0] m, input logic g);
        b_valid = v; b_write = w; b_addr = addr; b_wdata = d; b_wmask = m; b_wgrubby = g;
    endtask

    task automatic push_mem(input logic w, input logic [31:0] addr, input logic [31:0] d,
                            input logic [3:0] m, input logic g);
        exp_mem.push_back('{w: w, addr: addr, wdata: d, mask: m, g: g});
    endtask

    task automatic push_rsp(input logic [31:0] d, input logic g);
        exp_rsp.push_back('{data: d, g: g});
    endtask

    logic [31:0] bb_data [3];
    logic        bb_g    [3];

    initial begin
        bb_data[0] = 32'hC0DE0000; bb_g[0] = 1'b0;
        bb_data[1] = 32'hC0DE0004; bb_g[1] = 1'b1;
        bb_data[2] = 32'hC0DE0008; bb_g[2] = 1'b0;

        rst = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_b_rvalid", 32'(b_rvalid), 0);
        chk("rst_starved", 32'(starved), 0);
        chk("rst_wait_count", 32'(wait_count), 0);
        chk("rst_b_ready", 32'(b_ready), 1);
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_mem_wmask", 32'(mem_wmask), 0);

        // Single B read with A idle: issue at +1, response at +2.
        tick();
        drive_b(1, 0, 32'h100, 0, 0, 0);
        #1 chk("t1_b_ready", 32'(b_ready), 1);
        tick();
        b_valid = 0;
        push_mem(0, 32'h100, 0, 0, 0);
        push_rsp(32'hC0DE0100, 1'b0);
        #1;
        chk("t1_mem_valid", 32'(mem_valid), 1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        tick();
        #1 chk("t1_b_rvalid", 32'(b_rvalid), 1);

        // B write parked behind 10 further busy A cycles; starvation at wait 4.
        tick();
        drive_a(1, 0, 32'h300, 0, 0, 0);
        drive_b(1, 1, 32'h200, 32'hDEADBEEF, 4'hF, 1'b1);
        push_mem(0, 32'h300, 0, 0, 0);
        #1 chk("t2_b_ready_idle", 32'(b_ready), 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            drive_a(1, 0, 32'h300 + 32'(4 * k), 0, 0, 0);
            b_valid = 0;
            push_mem(0, 32'h300 + 32'(4 * k), 0, 0, 0);
            #1;
            if (k == 1) chk("t2_b_ready_busy", 32'(b_ready), 0);
            if (k == 4) begin
                chk("t3_wait_3", 32'(wait_count), 3);
                chk("t3_starved_lo", 32'(starved), 0);
            end
            if (k == 5) begin
                chk("t3_wait_4", 32'(wait_count), 4);
                chk("t3_starved_hi", 32'(starved), 1);
            end
        end
        tick();
        a_valid = 0;
        push_mem(1, 32'h200, 32'hDEADBEEF, 4'hF, 1'b1);
        #1;
        chk("t2_wait_10", 32'(wait_count), 10);
        chk("t3_starved_at_issue", 32'(starved), 1);
        chk("t2_b_ready_issue", 32'(b_ready), 1);
        tick();
        drive_b(1, 0, 32'h200, 0, 0, 0);
        #1;
        chk("t3_starved_clear", 32'(starved), 0);
        chk("t2_wait_clear", 32'(wait_count), 0);
        chk("t2_no_write_rvalid", 32'(b_rvalid), 0);
        tick();
        b_valid = 0;
        push_mem(0, 32'h200, 0, 0, 0);
        push_rsp(32'hDEADBEEF, 1'b1);
        tick();
        #1 chk("t2_readback_rvalid", 32'(b_rvalid), 1);

        // Wait counter saturation at 15.
        tick();
        drive_a(1, 0, 32'h100, 0, 0, 0);
        drive_b(1, 0, 32'h8, 0, 0, 0);
        push_mem(0, 32'h100, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            drive_a(1, 0, 32'h100 + 32'(4 * k), 0, 0, 0);
            b_valid = 0;
            push_mem(0, 32'h100 + 32'(4 * k), 0, 0, 0);
            #1;
            if (k == 15) chk("sat_wait_14", 32'(wait_count), 14);
            if (k == 20) chk("sat_wait_15", 32'(wait_count), 15);
        end
        tick();
        a_valid = 0;
        push_mem(0, 32'h8, 0, 0, 0);
        push_rsp(32'hC0DE0008, 1'b0);
        #1 chk("sat_wait_at_issue", 32'(wait_count), 15);
        tick();
        #1 chk("sat_wait_clear", 32'(wait_count), 0);

        // Back-to-back B reads with A idle.
        for (int k = 0; k <= 4; k++) begin
            tick();
            if (k < 3) drive_b(1, 0, 32'(4 * k), 0, 0, 0);
            else b_valid = 0;
            if (k >= 1 && k <= 3) begin
                push_mem(0, 32'(4 * (k - 1)), 0, 0, 0);
                push_rsp(bb_data[k - 1], bb_g[k - 1]);
            end
            #1;
            if (k < 3) chk("b2b_b_ready", 32'(b_ready), 1);
            if (k >= 2) chk("b2b_b_rvalid", 32'(b_rvalid), 1);
        end
        tick();
        #1 chk("b2b_rvalid_end", 32'(b_rvalid), 0);

        // A collides with pending B; refused B must not disturb the buffer.
        tick();
        drive_a(1, 1, 32'h3F0, 32'h12345678, 4'h3, 1'b1);
        drive_b(1, 0, 32'h80, 0, 0, 0);
        push_mem(1, 32'h3F0, 32'h12345678, 4'h3, 1'b1);
        tick();
        drive_a(1, 0, 32'h40, 0, 0, 0);
        drive_b(1, 0, 32'hC0, 0, 0, 0);
        push_mem(0, 32'h40, 0, 0, 0);
        #1;
        chk("col_mem_addr_a", mem_addr, 32'h40);
        chk("col_b_ready", 32'(b_ready), 0);
        tick();
        a_valid = 0;
        push_mem(0, 32'h80, 0, 0, 0);
        push_rsp(32'hC0DE0080, 1'b0);
        #1;
        chk("col_mem_addr_b", mem_addr, 32'h80);
        chk("col_b_ready_issue", 32'(b_ready), 1);
        tick();
        b_valid = 0;
        push_mem(0, 32'hC0, 0, 0, 0);
        push_rsp(32'hC0DE00C0, 1'b0);
        repeat (2) tick();

        // Reset during an in-flight B read: no response afterwards.
        drive_b(1, 0, 32'h10, 0, 0, 0);
        tick();
        b_valid = 0;
        rst = 1;
        push_mem(0, 32'h10, 0, 0, 0);
        tick();
        rst = 0;
        drive_a(1, 0, 32'h50, 0, 0, 0);
        push_mem(0, 32'h50, 0, 0, 0);
        #1;
        chk("rsta_b_rvalid", 32'(b_rvalid), 0);
        chk("rsta_b_ready_idle", 32'(b_ready), 1);
        chk("rsta_mem_valid_a", 32'(mem_valid), 1);
        chk("rsta_wait", 32'(wait_count), 0);

        // Reset while a B request is pending behind A: it is dropped.
        tick();
        drive_a(1, 0, 32'h54, 0, 0, 0);
        drive_b(1, 0, 32'h20, 0, 0, 0);
        push_mem(0, 32'h54, 0, 0, 0);
        tick();
        drive_a(1, 0, 32'h58, 0, 0, 0);
        b_valid = 0;
        rst = 1;
        push_mem(0, 32'h58, 0, 0, 0);
        tick();
        rst = 0;
        a_valid = 0;
        #1;
        chk("rstb_mem_valid", 32'(mem_valid), 0);
        chk("rstb_b_ready", 32'(b_ready), 1);
        chk("rstb_wait", 32'(wait_count), 0);
        chk("rstb_starved", 32'(starved), 0);
        repeat (3) tick();

        chk("exp_mem_drained", 32'(exp_mem.size()), 0);
        chk("exp_rsp_drained", 32'(exp_rsp.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1, "watchdog");
    end

endmodule
